// File: rtl/cpu_pkg.sv
// cpu_pkg: shared datapath widths and operand-select encodings for the operand stage.
package cpu_pkg;
   localparam int XLEN   = 32;
   localparam int REG_AW = 5;
   typedef enum logic {A_RS1 = 1'b0, A_PC  = 1'b1} opnd_a_sel_e;
   typedef enum logic {B_RS2 = 1'b0, B_IMM = 1'b1} opnd_b_sel_e;
endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: combinational source-operand forwarding selector for one register read port.
// Ports: idx/rf_data = register index and regfile read data; exm_*/mwb_* = EX/MEM and
// MEM/WB writeback candidates; data = resolved source value (x0 always reads as zero).
// Macro OPND_FWD_EN: when defined, EX/MEM then MEM/WB results are bypassed; when
// undefined, the writeback candidates are ignored and only the regfile value is used.
module fwd_mux
   import cpu_pkg::*;
(
   input  logic [REG_AW-1:0] idx,
   input  logic [XLEN-1:0]   rf_data,
   input  logic              exm_wen,
   input  logic [REG_AW-1:0] exm_idx,
   input  logic [XLEN-1:0]   exm_data,
   input  logic              mwb_wen,
   input  logic [REG_AW-1:0] mwb_idx,
   input  logic [XLEN-1:0]   mwb_data,
   output logic [XLEN-1:0]   data
);
   logic nz;
   assign nz = idx != '0;
`ifdef OPND_FWD_EN
   // EX/MEM holds the younger result, so it wins over MEM/WB
   assign data = !nz                           ? '0       :
                 (exm_wen && exm_idx == idx)   ? exm_data :
                 (mwb_wen && mwb_idx == idx)   ? mwb_data : rf_data;
`else
   logic unused_fwd;
   assign unused_fwd = ^{exm_wen, exm_idx, exm_data, mwb_wen, mwb_idx, mwb_data};
   assign data = nz ? rf_data : '0;
`endif
endmodule

// File: rtl/alu_opnd_stage.sv
// alu_opnd_stage: ID/EX register feeding the ALU adder operands with forwarding, stall and flush.
// Ports: clk_i/rst_n_i = clock and async active-low reset; valid_i/ready_o = decode handshake;
// pc_i, rs*_idx_i, rs*_data_i, imm_i, a_sel_i, b_sel_i = decode operands and selects;
// exm_*/mwb_* = forwarding sources; flush_i = kill; ready_i/valid_o = EX handshake;
// a_o, b_o, rs2_fwd_o = registered operands and store data.
// Macro OPND_FWD_EN enables the forwarding network (see fwd_mux).
module alu_opnd_stage
   import cpu_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [XLEN-1:0]   pc_i,
   input  logic [REG_AW-1:0] rs1_idx_i,
   input  logic [REG_AW-1:0] rs2_idx_i,
   input  logic [XLEN-1:0]   rs1_data_i,
   input  logic [XLEN-1:0]   rs2_data_i,
   input  logic [XLEN-1:0]   imm_i,
   input  logic              a_sel_i,
   input  logic              b_sel_i,
   input  logic              exm_wen_i,
   input  logic [REG_AW-1:0] exm_idx_i,
   input  logic [XLEN-1:0]   exm_data_i,
   input  logic              mwb_wen_i,
   input  logic [REG_AW-1:0] mwb_idx_i,
   input  logic [XLEN-1:0]   mwb_data_i,
   input  logic              flush_i,
   input  logic              ready_i,
   output logic              valid_o,
   output logic [XLEN-1:0]   a_o,
   output logic [XLEN-1:0]   b_o,
   output logic [XLEN-1:0]   rs2_fwd_o
);
   logic [XLEN-1:0] fwd_rs1, fwd_rs2;
   logic            cap;
   fwd_mux u_fwd1 (
      .idx(rs1_idx_i), .rf_data(rs1_data_i),
      .exm_wen(exm_wen_i), .exm_idx(exm_idx_i), .exm_data(exm_data_i),
      .mwb_wen(mwb_wen_i), .mwb_idx(mwb_idx_i), .mwb_data(mwb_data_i),
      .data(fwd_rs1)
   );
   fwd_mux u_fwd2 (
      .idx(rs2_idx_i), .rf_data(rs2_data_i),
      .exm_wen(exm_wen_i), .exm_idx(exm_idx_i), .exm_data(exm_data_i),
      .mwb_wen(mwb_wen_i), .mwb_idx(mwb_idx_i), .mwb_data(mwb_data_i),
      .data(fwd_rs2)
   );
   assign ready_o = !valid_o || ready_i;
   assign cap     = valid_i && ready_o && !flush_i;
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         valid_o   <= 1'b0;
         a_o       <= '0;
         b_o       <= '0;
         rs2_fwd_o <= '0;
      end else begin
         valid_o <= flush_i ? 1'b0 : (ready_o ? valid_i : valid_o);
         if (cap) begin
            a_o       <= opnd_a_sel_e'(a_sel_i) == A_PC  ? pc_i  : fwd_rs1;
            b_o       <= opnd_b_sel_e'(b_sel_i) == B_IMM ? imm_i : fwd_rs2;
            rs2_fwd_o <= fwd_rs2;
         end
      end
   end
endmodule

// File: tb/tb_alu_opnd_stage.sv
// tb_alu_opnd_stage: directed vector bench for alu_opnd_stage.
module tb_alu_opnd_stage;
`ifdef OPND_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        valid_i = 0, ready_o, a_sel = 0, b_sel = 0, exm_wen = 0, mwb_wen = 0;
   logic        flush = 0, ready_i = 0, valid_o;
   logic [31:0] pc = 0, rs1_data = 0, rs2_data = 0, imm = 0, exm_data = 0, mwb_data = 0;
   logic [31:0] a_o, b_o, rs2_fwd;
   logic [4:0]  rs1_idx = 0, rs2_idx = 0, exm_idx = 0, mwb_idx = 0;
   int total = 0, bad = 0;
   typedef struct {
      logic [4:0]  r1i, r2i;
      logic [31:0] r1d, r2d, pcv, immv;
      logic        as, bs, ew;
      logic [4:0]  ei;
      logic [31:0] ed;
      logic        mw;
      logic [4:0]  mi;
      logic [31:0] md, ea, eb, er;
   } vec_t;
   vec_t tv[8];
   always #5 clk = ~clk;
   alu_opnd_stage dut (
      .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid_i), .ready_o(ready_o), .pc_i(pc),
      .rs1_idx_i(rs1_idx), .rs2_idx_i(rs2_idx), .rs1_data_i(rs1_data), .rs2_data_i(rs2_data),
      .imm_i(imm), .a_sel_i(a_sel), .b_sel_i(b_sel),
      .exm_wen_i(exm_wen), .exm_idx_i(exm_idx), .exm_data_i(exm_data),
      .mwb_wen_i(mwb_wen), .mwb_idx_i(mwb_idx), .mwb_data_i(mwb_data),
      .flush_i(flush), .ready_i(ready_i), .valid_o(valid_o),
      .a_o(a_o), .b_o(b_o), .rs2_fwd_o(rs2_fwd)
   );
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic drive(input vec_t v);
      rs1_idx = v.r1i; rs2_idx = v.r2i; rs1_data = v.r1d; rs2_data = v.r2d;
      pc = v.pcv; imm = v.immv; a_sel = v.as; b_sel = v.bs;
      exm_wen = v.ew; exm_idx = v.ei; exm_data = v.ed;
      mwb_wen = v.mw; mwb_idx = v.mi; mwb_data = v.md;
   endtask
   initial begin
      tv[0] = '{1, 2, 32'h10, 32'h22, 32'h0, 32'h4, 1, 1, 0, 0, 0, 0, 0, 0, 32'h10, 32'h4, 32'h22};
      tv[0].as = 0;
      tv[1] = '{1, 3, 32'h11, 32'h33, 32'h1000, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h1000, 32'h33, 32'h33};
      tv[2] = '{5, 6, 32'h55, 32'h66, 32'h0, 32'h8, 0, 1, 1, 5, 32'hAAAA, 1, 5, 32'hBBBB,
                FWD ? 32'hAAAA : 32'h55, 32'h8, 32'h66};
      tv[3] = '{5, 6, 32'h55, 32'h66, 32'h0, 32'h8, 0, 1, 0, 5, 32'hAAAA, 1, 5, 32'hBBBB,
                FWD ? 32'hBBBB : 32'h55, 32'h8, 32'h66};
      tv[4] = '{0, 6, 32'hDEAD, 32'h66, 32'h0, 32'h8, 0, 1, 1, 0, 32'hAAAA, 1, 0, 32'hBBBB,
                32'h0, 32'h8, 32'h66};
      tv[5] = '{8, 7, 32'h88, 32'h77, 32'h0, 32'h0, 0, 0, 1, 8, 32'h1, 1, 7, 32'hC0DE,
                FWD ? 32'h1 : 32'h88, FWD ? 32'hC0DE : 32'h77, FWD ? 32'hC0DE : 32'h77};
      tv[6] = '{3, 4, 32'h7, 32'h44, 32'h0, 32'h0, 0, 0, 1, 3, 32'h999, 0, 0, 0,
                FWD ? 32'h999 : 32'h7, 32'h44, 32'h44};
      tv[7] = '{9, 0, 32'h99, 32'hFFFF, 32'h0, 32'h0, 0, 0, 0, 0, 0, 1, 0, 32'h1234,
                32'h99, 32'h0, 32'h0};
      #2;
      chk("rst_valid", {31'b0, valid_o}, 0);
      chk("rst_a", a_o, 0);
      chk("rst_b", b_o, 0);
      chk("rst_rs2", rs2_fwd, 0);
      cyc();
      rst_n = 1'b1;
      ready_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(tv[i]);
         valid_i = 1'b1;
         #1;
         chk($sformatf("v%0d_ready", i), {31'b0, ready_o}, 1);
         cyc();
         chk($sformatf("v%0d_valid", i), {31'b0, valid_o}, 1);
         chk($sformatf("v%0d_a", i), a_o, tv[i].ea);
         chk($sformatf("v%0d_b", i), b_o, tv[i].eb);
         chk($sformatf("v%0d_rs2", i), rs2_fwd, tv[i].er);
      end
      // backpressure: vector 1 held while a different instruction waits
      drive(tv[1]);
      cyc();
      drive(tv[0]);
      ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_ready", {31'b0, ready_o}, 0);
         cyc();
         chk("bp_valid", {31'b0, valid_o}, 1);
         chk("bp_a", a_o, 32'h1000);
         chk("bp_b", b_o, 32'h33);
      end
      ready_i = 1'b1;
      cyc();
      chk("bp_rel_valid", {31'b0, valid_o}, 1);
      chk("bp_rel_a", a_o, 32'h10);
      chk("bp_rel_b", b_o, 32'h4);
      // drain: no new instruction, data stays put
      valid_i = 1'b0;
      cyc();
      chk("drain_valid", {31'b0, valid_o}, 0);
      chk("drain_a", a_o, 32'h10);
      // flush while both held and incoming are valid
      drive(tv[1]);
      valid_i = 1'b1;
      cyc();
      chk("pre_flush_valid", {31'b0, valid_o}, 1);
      drive(tv[7]);
      flush = 1'b1;
      cyc();
      chk("flush_valid", {31'b0, valid_o}, 0);
      flush = 1'b0;
      valid_i = 1'b0;
      cyc();
      chk("flush_no_ghost", {31'b0, valid_o}, 0);
      // async reset mid-stream
      drive(tv[0]);
      valid_i = 1'b1;
      cyc();
      chk("pre_rst_valid", {31'b0, valid_o}, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", {31'b0, valid_o}, 0);
      chk("arst_a", a_o, 0);
      chk("arst_b", b_o, 0);
      chk("arst_rs2", rs2_fwd, 0);
      cyc();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
